// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller.
//   state_t      : controller state encoding (RUN / DMISS / IMISS)
//   REG_ZERO     : architectural register 0, never a hazard source
//   CNT_SIZE_DEF : default width of the stall and perf counters
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DMISS = 2'd1,
        ST_IMISS = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         CNT_SIZE_DEF = 16;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter
//   Saturating up-counter updated on the falling clock edge, matching the
//   pipeline registers. Clear has priority over increment.
//   clk   : pipeline clock (state changes on negedge)
//   rst   : asynchronous reset, active-low
//   clr   : synchronous clear to 0
//   inc   : increment by one, holding at all-ones
//   cnt   : current count
module sat_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int width = CNT_SIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] cnt
);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Central stall/flush controller for the 5-stage pipeline with I/D caches.
//   Hold/flush outputs are combinational from the current state and inputs;
//   state, stall_cnt and timeout_err update on the falling clock edge.
//   Optional build macro: HAZARD_PERF_CNT_EN adds perf_loaduse,
//   perf_dmiss_cyc and perf_imiss_cyc saturating counters.
//
//   Inputs : clk, rst (async, active-low), EX_Read_enable, EX_WR_out,
//            ID_Rs, ID_Rt, ID_uses_rt, ID_branch_taken, I_ready,
//            MEM_D_req, D_ready
//   Outputs: PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite
//            (1 = hold), IF_Flush, ID_Flush, stall_cnt, timeout_err
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | normal flow; load-use and branch flushes evaluated here
//   ST_DMISS | waiting on D-cache; whole pipeline held
//   ST_IMISS | waiting on I-cache; PC held, bubbles fed into IF/ID
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int cnt_size     = CNT_SIZE_DEF,
    parameter int miss_timeout = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EX_Read_enable,
    input  logic [4:0]          EX_WR_out,
    input  logic [4:0]          ID_Rs,
    input  logic [4:0]          ID_Rt,
    input  logic                ID_uses_rt,
    input  logic                ID_branch_taken,
    input  logic                I_ready,
    input  logic                MEM_D_req,
    input  logic                D_ready,
    output logic                PCWrite,
    output logic                IFIDWrite,
    output logic                IDEXWrite,
    output logic                EXMEMWrite,
    output logic                MEMWBWrite,
    output logic                IF_Flush,
    output logic                ID_Flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [cnt_size-1:0] perf_loaduse,
    output logic [cnt_size-1:0] perf_dmiss_cyc,
    output logic [cnt_size-1:0] perf_imiss_cyc,
`endif
    output logic [cnt_size-1:0] stall_cnt,
    output logic                timeout_err
);

    localparam logic [cnt_size-1:0] TIMEOUT_VAL = cnt_size'(miss_timeout);

    state_t state;
    state_t next_state;
    logic   d_miss;
    logic   load_use;
    logic   pc_hold, ifid_hold, down_hold, if_flush, id_flush;
    logic   cnt_clr;
    logic   at_limit;
    logic   err_q;

    always_comb begin
        d_miss    = MEM_D_req && !D_ready;
        load_use  = (state == ST_RUN) && EX_Read_enable && (EX_WR_out != REG_ZERO) &&
                    ((EX_WR_out == ID_Rs) || (ID_uses_rt && (EX_WR_out == ID_Rt)));
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        down_hold  = 1'b0;
        if_flush   = 1'b0;
        id_flush   = 1'b0;
        next_state = ST_RUN;

        if (d_miss) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            down_hold  = 1'b1;
            next_state = ST_DMISS;
        end else if (state == ST_DMISS) begin
            // Release cycle: everything moves; an outstanding I-miss is
            // picked up again from the next cycle.
            next_state = I_ready ? ST_RUN : ST_IMISS;
        end else if (!I_ready) begin
            pc_hold    = 1'b1;
            if_flush   = 1'b1;
            next_state = ST_IMISS;
        end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            id_flush   = 1'b1;
        end else if (ID_branch_taken) begin
            if_flush   = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Count restarts on return to RUN and on a DMISS<->IMISS hand-over.
    assign cnt_clr = (next_state == ST_RUN) ||
                     ((state != ST_RUN) && (next_state != state));

    sat_counter #(.width(cnt_size)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (1'b1),
        .cnt (stall_cnt)
    );

    assign at_limit = (state != ST_RUN) && (stall_cnt == TIMEOUT_VAL);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (at_limit) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_err = rst & (err_q | at_limit);

    assign PCWrite    = rst & pc_hold;
    assign IFIDWrite  = rst & ifid_hold;
    assign IDEXWrite  = rst & down_hold;
    assign EXMEMWrite = rst & down_hold;
    assign MEMWBWrite = rst & down_hold;
    assign IF_Flush   = rst & if_flush;
    assign ID_Flush   = rst & id_flush;

`ifdef HAZARD_PERF_CNT_EN
    // ID_Flush is raised only for a load-use bubble.
    sat_counter #(.width(cnt_size)) u_perf_loaduse (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ID_Flush),
        .cnt (perf_loaduse)
    );

    sat_counter #(.width(cnt_size)) u_perf_dmiss (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (state == ST_DMISS),
        .cnt (perf_dmiss_cyc)
    );

    sat_counter #(.width(cnt_size)) u_perf_imiss (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (state == ST_IMISS),
        .cnt (perf_imiss_cyc)
    );
`endif

endmodule
